// File: rtl/mpx_icache_pkg.sv
// Shared definitions for the MPX instruction cache.
// Holds the FSM state encodings and the helpers that split a 32-bit fetch
// address into offset / index / tag fields for a given cache geometry.
package mpx_icache_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_LOOKUP      = 3'd1;
  localparam logic [2:0] ST_REFILL_REQ  = 3'd2;
  localparam logic [2:0] ST_REFILL_DATA = 3'd3;
  localparam logic [2:0] ST_RESPOND     = 3'd4;
  localparam logic [2:0] ST_FLUSH       = 3'd5;

  // Word-offset bits within a line.
  function automatic int unsigned offw(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Line-index bits.
  function automatic int unsigned idxw(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag bits: everything above index, offset and the byte-in-word bits.
  function automatic int unsigned tagw(input int unsigned num_lines,
                                       input int unsigned line_words);
    return 32 - idxw(num_lines) - offw(line_words) - 2;
  endfunction

  // Field widths for the default 256-line, 8-word geometry.
  localparam int unsigned OFFW = offw(8);
  localparam int unsigned IDXW = idxw(256);
  localparam int unsigned TAGW = tagw(256, 8);

endpackage

// File: rtl/mpx_icache_data_ram.sv
// Single-port, synchronous-read, word-write RAM.
// Ports: clk_i clock; addr_i word address; wr_i write strobe;
//        wdata_i write data; rdata_o registered read data (old contents
//        are returned on a write cycle).
module mpx_icache_data_ram #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mpx_icache.sv
// Direct-mapped read-only instruction cache for the MPX fetch stage.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_rd_i/req_pc_i/req_priv_i  fetch request (priv unused, no MMU)
//   req_flush_i/req_invalidate_i  invalidate-all pulses
//   req_accept_o                  request taken this cycle
//   req_valid_o/error_o/inst_o    one-cycle response, error => NOP
//   mem_rd_o/addr_o/len_o         line refill burst request
//   mem_accept_i/valid_i/data_i/error_i  refill handshake and beats
module mpx_icache
  import mpx_icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 256,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_rd_i,
  input  logic [31:0] req_pc_i,
  input  logic        req_priv_i,
  input  logic        req_flush_i,
  input  logic        req_invalidate_i,
  output logic        req_accept_o,
  output logic        req_valid_o,
  output logic        req_error_o,
  output logic [31:0] req_inst_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_len_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_error_i
);

  localparam int unsigned OFF_W   = offw(LINE_WORDS);
  localparam int unsigned IDX_W   = idxw(NUM_LINES);
  localparam int unsigned TAG_W   = tagw(NUM_LINES, LINE_WORDS);
  localparam int unsigned TAG_LSB = OFF_W + IDX_W + 2;

  logic [2:0]           state_q, state_d;
  logic [31:2]          pc_q;
  logic                 flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [OFF_W-1:0]     beat_q, beat_d;
  logic                 err_q, err_d;
  logic [31:0]          inst_q, inst_d;

  logic [IDX_W-1:0]       cur_idx, req_idx;
  logic [OFF_W-1:0]       cur_off, req_off;
  logic [TAG_W-1:0]       cur_tag;
  logic                   hit, last_beat, take_req, ram_wr;
  logic [IDX_W+OFF_W-1:0] ram_addr;
  logic [31:0]            ram_rdata;
  logic                   unused_ok;

  assign unused_ok = ^{req_priv_i, req_pc_i[1:0]};

  assign cur_idx = pc_q[TAG_LSB-1:OFF_W+2];
  assign cur_off = pc_q[OFF_W+1:2];
  assign cur_tag = pc_q[31:TAG_LSB];
  assign req_idx = req_pc_i[TAG_LSB-1:OFF_W+2];
  assign req_off = req_pc_i[OFF_W+1:2];

  assign hit       = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign last_beat = mem_valid_i && (beat_q == OFF_W'(LINE_WORDS - 1));
  assign take_req  = req_accept_o && req_rd_i;
  assign ram_wr    = (state_q == ST_REFILL_DATA) && mem_valid_i;

  // Outside a refill the RAM always reads at the incoming PC, so the word
  // for any request accepted this cycle is ready in LOOKUP.
  assign ram_addr = (state_q == ST_REFILL_DATA) ? {cur_idx, beat_q}
                                                : {req_idx, req_off};

  assign mem_len_o  = 8'(LINE_WORDS - 1);
  assign mem_addr_o = (state_q == ST_REFILL_REQ)
                    ? {pc_q[31:OFF_W+2], {(OFF_W + 2){1'b0}}} : '0;

  mpx_icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .WIDTH (32)
  ) u_data_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_addr),
    .wr_i    (ram_wr),
    .wdata_i (mem_data_i),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q | req_flush_i | req_invalidate_i;
    valid_d      = valid_q;
    beat_d       = beat_q;
    err_d        = err_q;
    inst_d       = inst_q;
    req_accept_o = 1'b0;
    req_valid_o  = 1'b0;
    req_error_o  = 1'b0;
    req_inst_o   = '0;
    mem_rd_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_accept_o = !flush_pend_q;
        if (flush_pend_q) state_d = ST_FLUSH;
        else if (req_rd_i) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          req_valid_o  = 1'b1;
          req_inst_o   = ram_rdata;
          // A pending flush blocks the next request so FLUSH runs right
          // after this response.
          req_accept_o = !flush_pend_q;
          if (flush_pend_q) state_d = ST_FLUSH;
          else if (req_rd_i) state_d = ST_LOOKUP;
          else state_d = ST_IDLE;
        end else begin
          state_d = ST_REFILL_REQ;
        end
      end
      ST_REFILL_REQ: begin
        mem_rd_o = 1'b1;
        if (mem_accept_i) begin
          beat_d           = '0;
          err_d            = 1'b0;
          valid_d[cur_idx] = 1'b0;
          state_d          = ST_REFILL_DATA;
        end
      end
      ST_REFILL_DATA: begin
        if (mem_valid_i) begin
          beat_d = beat_q + 1'b1;
          err_d  = err_q | mem_error_i;
          if (beat_q == cur_off) inst_d = mem_data_i;
          if (last_beat) begin
            valid_d[cur_idx] = !(err_q | mem_error_i);
            state_d          = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        req_valid_o = 1'b1;
        req_error_o = err_q;
        req_inst_o  = err_q ? '0 : inst_q;
        state_d     = ST_IDLE;
      end
      ST_FLUSH: begin
        valid_d      = '0;
        flush_pend_d = req_flush_i | req_invalidate_i;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      inst_q       <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      inst_q       <= inst_d;
      if (take_req) pc_q <= req_pc_i[31:2];
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state_q == ST_REFILL_DATA) && last_beat) tag_q[cur_idx] <= cur_tag;
  end

endmodule

// File: doc/mpx_icache.md
# mpx_icache

Direct-mapped, read-only instruction cache sitting between the MPX fetch stage and the memory fabric. It accepts one fetch request at a time, returns hits with a single cycle of latency, and refills whole lines over a burst memory port. It also supports cache-wide flush and propagates memory bus errors to fetch as instruction faults.

## Interface
Parameters:
- NUM_LINES, 256, number of cache lines; power of two, at least 2.
- LINE_WORDS, 8, 32-bit words per line; power of two, 2 to 16.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_rd_i  in  1  fetch read request, qualified by req_accept_o.
- req_pc_i  in  32  fetch address; bits [1:0] are ignored.
- req_priv_i  in  1  privilege level; ignored because there is no MMU.
- req_flush_i  in  1  invalidate all lines (pulse).
- req_invalidate_i  in  1  treated identically to req_flush_i.
- req_accept_o  out  1  request accepted this cycle.
- req_valid_o  out  1  response valid, one-cycle pulse.
- req_error_o  out  1  response is a bus fault; qualified by req_valid_o.
- req_inst_o  out  32  instruction word.
- mem_rd_o  out  1  line refill request; held until mem_accept_i.
- mem_addr_o  out  32  line-aligned refill address.
- mem_len_o  out  8  beats minus one, equal to LINE_WORDS-1.
- mem_accept_i  in  1  refill request accepted.
- mem_valid_i  in  1  refill data beat.
- mem_data_i  in  32  refill data.
- mem_error_i  in  1  beat error; qualified by mem_valid_i.

## Operation
- Address split:
  - offset = pc[OFFW+1:2], where OFFW = log2(LINE_WORDS).
  - index = next log2(NUM_LINES) bits.
  - tag = the remaining upper bits.
- Storage:
  - Valid bits: flop array.
  - Tags: flop or RAM array.
  - Data: synchronous-read RAM of NUM_LINES*LINE_WORDS words.
- States are IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND and FLUSH.
- IDLE:
  - req_accept_o = 1 unless a flush is pending.
  - When req_rd_i is high, latch the PC, start the data/tag read and go to LOOKUP.
- LOOKUP:
  - Hit (valid and tag match): req_valid_o = 1 with RAM data and req_accept_o = 1, so back-to-back requests are allowed. Go to LOOKUP on a new request, otherwise IDLE.
  - Miss: go to REFILL_REQ with req_accept_o = 0.
- REFILL_REQ:
  - mem_rd_o = 1 and mem_addr_o = {tag, index, OFFW+2'b0}.
  - On mem_accept_i, clear the beat counter and the error flag, invalidate the line, then go to REFILL_DATA.
- REFILL_DATA:
  - On each mem_valid_i, write the word at the beat counter and increment the counter.
  - Capture the beat whose counter equals the requested offset.
  - OR mem_error_i into the sticky error flag.
  - On the final beat (counter = LINE_WORDS-1), write the tag and set valid = !error, then go to RESPOND.
- RESPOND:
  - req_valid_o = 1, req_inst_o = captured word, req_error_o = error flag.
  - On error, req_inst_o is forced to 0 (NOP).
  - Go to IDLE; no request is accepted in this state.
- Flush:
  - A req_flush_i or req_invalidate_i asserted in any state sets flush_pending.
  - flush_pending is acted on only from IDLE, or from LOOKUP after the response has completed.
  - FLUSH clears every valid bit in one cycle, clears flush_pending, and returns to IDLE. req_accept_o = 0 during FLUSH.
  - A flush during a refill does not abort the burst. The response is still delivered, and the line is then invalidated by the pending flush.
- Every request produces exactly one req_valid_o pulse. A request must never be dropped or duplicated.

## Timing
- Reset values:
  - State = IDLE, all valid bits = 0, flush_pending = 0.
  - req_accept_o = 1, req_valid_o = 0, req_error_o = 0, req_inst_o = 0.
  - mem_rd_o = 0, mem_addr_o = 0, mem_len_o = LINE_WORDS-1.
- Hit latency: req_valid_o is asserted 1 cycle after accept. Sustained throughput is 1 hit per cycle.
- Miss latency: 1 (lookup) + request wait + LINE_WORDS beats + 1 (respond), counted from accept to req_valid_o.
- mem_rd_o and mem_addr_o stay stable until mem_accept_i is seen.
- Reset asserted mid-refill returns the block to IDLE with all lines invalid. Any remaining beats from the fabric are ignored, because mem_valid_i is only honoured in REFILL_DATA.
- A flush asserted in the same cycle as an accepted request is handled as follows: the request completes first, then FLUSH runs.

## Structure
- A shared package holds:
  - The state enumeration.
  - Address field width functions and OFFW/IDXW/TAGW localparams.
- One sub-module, mpx_icache_data_ram: a single-port, synchronous-read, word-write RAM with parameters for depth and width, usable by a later data cache.

## Test plan
- Cold miss to 0x1000 with memory returning 8 beats of 0xA0+i: mem_addr_o = 0x1000, and req_inst_o = 0xA0 arrives one cycle after the last beat. A repeat read of 0x1004 then hits in 1 cycle with 0xA1.
- Back-to-back hits on 0x1000, 0x1004, 0x1008: req_accept_o stays high and the block produces three consecutive req_valid_o pulses.
- Refill where beat 3 has mem_error_i: req_error_o = 1 and req_inst_o = 0. A re-read of the same line misses again.
- Alias test, with 0x1000 then 0x1000 + NUM_LINES*LINE_WORDS*4: the second request evicts the line, so a return to 0x1000 misses.
- req_flush_i pulsed mid-burst: the burst completes and the response is delivered, FLUSH runs, and the next read of the same line misses.
- rst_ni asserted at beat 4 of a refill: all outputs take their reset values, and post-reset reads of that line miss.
